// File: rtl/rdma_gen_pkg.sv
// Shared types and constants for the rdma_gen read-DMA generator.
// Holds the AR state encoding and the 4 KB boundary helper.
package rdma_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_DRAIN
   } state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         BOUNDARY_BYTES = 4096;

   // Beats that fit between an aligned address and the next 4 KB boundary.
   function automatic logic [12:0] beats_to_boundary(input logic [11:0] addr_lo,
                                                     input int unsigned size_log2);
      logic [12:0] bytes_left;
      bytes_left = 13'(BOUNDARY_BYTES) - {1'b0, addr_lo};
      return bytes_left >> size_log2;
   endfunction

endpackage

// File: rtl/rdma_gen_if.sv
// Descriptor, AXI AR/R and output-stream signals of rdma_gen.
// master = the DMA engine side, slave = memory/consumer side.
interface rdma_gen_if #(
   parameter int DATA_W = 64
);
   logic              desc_valid;
   logic              desc_ready;
   logic [31:0]       desc_addr;
   logic [15:0]       desc_beats;

   logic              m_axi_arvalid;
   logic              m_axi_arready;
   logic [31:0]       m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;

   logic              m_axi_rvalid;
   logic              m_axi_rready;
   logic [DATA_W-1:0] m_axi_rdata;
   logic              m_axi_rlast;
   logic [1:0]        m_axi_rresp;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      input  desc_valid, desc_addr, desc_beats,
      output desc_ready,
      output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
      input  m_axi_arready,
      input  m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
      output m_axi_rready,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      output desc_valid, desc_addr, desc_beats,
      input  desc_ready,
      input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
      output m_axi_arready,
      output m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
      input  m_axi_rready,
      input  out_valid, out_data, out_last,
      output out_ready
   );

endinterface

// File: rtl/rdma_len_fifo.sv
// Synchronous FIFO tracking the length of each in-flight AR burst.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module rdma_len_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rdma_gen.sv
// Descriptor-driven AXI read generator: splits a transfer into 4 KB-safe INCR bursts
// and streams the returned data. Optional rresp/rlast checking: RDMA_GEN_RESP_CHECK_EN.
module rdma_gen
   import rdma_gen_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int MAX_BURST   = 16,
   parameter int OUTSTANDING = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   rdma_gen_if.master bus,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned SZ = $clog2(DATA_W / 8);

   state_e      state;
   state_e      state_nxt;
   logic [31:0] cur_addr;
   logic [15:0] ar_rem;
   logic [15:0] r_rem;
   logic [8:0]  burst_len;
   logic [8:0]  beat_cnt;
   logic        ready_en;

   logic        accept;
   logic        ar_fire;
   logic        r_fire;
   logic        beat_last;
   logic        desc_last;
   logic        fifo_full;
   logic        fifo_empty;
   logic [8:0]  fifo_head;
   logic [8:0]  rem_clip;
   logic [12:0] btb;
   logic [8:0]  calc_len;

   assign accept         = bus.desc_valid & bus.desc_ready;
   assign bus.desc_ready = (state == S_IDLE) & ~done & ready_en;
   assign busy           = (state != S_IDLE) | done;

   assign bus.m_axi_arvalid = (state == S_ISSUE);
   assign bus.m_axi_araddr  = cur_addr;
   assign bus.m_axi_arlen   = 8'(burst_len - 9'd1);
   assign bus.m_axi_arsize  = 3'(SZ);
   assign bus.m_axi_arburst = AXI_BURST_INCR;
   assign ar_fire           = bus.m_axi_arvalid & bus.m_axi_arready;

   // Zero-latency R path, gated so data is only taken for bursts we issued.
   assign bus.m_axi_rready = bus.out_ready & ~fifo_empty;
   assign bus.out_valid    = bus.m_axi_rvalid & ~fifo_empty;
   assign bus.out_data     = bus.m_axi_rdata;
   assign r_fire           = bus.m_axi_rvalid & bus.m_axi_rready;
   assign beat_last        = (beat_cnt == fifo_head - 9'd1);
   assign desc_last        = (r_rem == 16'd1);
   assign bus.out_last     = bus.out_valid & desc_last;

   // Burst length = min(remaining, MAX_BURST, beats to the next 4 KB boundary).
   always_comb begin
      btb      = beats_to_boundary(cur_addr[11:0], SZ);
      rem_clip = (ar_rem > 16'(MAX_BURST)) ? 9'(MAX_BURST) : ar_rem[8:0];
      calc_len = ({4'b0, rem_clip} > btb) ? btb[8:0] : rem_clip;
   end

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && bus.desc_beats != 16'd0) state_nxt = S_CALC;
         S_CALC:  if (!fifo_full) state_nxt = S_ISSUE;
         S_ISSUE: if (ar_fire) state_nxt = (ar_rem == {7'b0, burst_len}) ? S_DRAIN : S_CALC;
         S_DRAIN: if (r_fire && desc_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         ar_rem    <= '0;
         r_rem     <= '0;
         burst_len <= '0;
         beat_cnt  <= '0;
         done      <= 1'b0;
         ready_en  <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         done     <= (accept && bus.desc_beats == 16'd0) || (r_fire && desc_last);
         if (accept) begin
            cur_addr <= bus.desc_addr & ~32'(DATA_W / 8 - 1);
            ar_rem   <= bus.desc_beats;
            r_rem    <= bus.desc_beats;
         end
         if (state == S_CALC && !fifo_full) burst_len <= calc_len;
         if (ar_fire) begin
            cur_addr <= cur_addr + ({23'b0, burst_len} << SZ);
            ar_rem   <= ar_rem - {7'b0, burst_len};
         end
         if (r_fire) begin
            r_rem    <= r_rem - 16'd1;
            beat_cnt <= beat_last ? 9'd0 : beat_cnt + 9'd1;
         end
      end
   end

   rdma_len_fifo #(
      .DEPTH(OUTSTANDING),
      .WIDTH(9)
   ) u_len_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ar_fire),
      .push_data(burst_len),
      .pop      (r_fire & beat_last),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef RDMA_GEN_RESP_CHECK_EN
   // Sticky until the next descriptor is accepted; the transfer itself carries on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (r_fire && (bus.m_axi_rresp != AXI_RESP_OKAY || bus.m_axi_rlast != beat_last)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/rdma_gen.md
RDMA_GEN -- requirements
Module: rdma_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the AXI read data width in bits (64 or 128).
REQ-002 The block SHALL have parameter MAX_BURST, default 16, giving the maximum beats per AR burst (1..256).
REQ-003 The block SHALL have parameter OUTSTANDING, default 4, giving the maximum number of in-flight AR bursts (power of 2, 2..16).
REQ-004 The block SHALL have one clock, clk (in, 1, rising-edge clock), with all logic synchronous to it.
REQ-005 The block SHALL have rst_n (in, 1), an asynchronous active-low reset.
REQ-006 The block SHALL have a descriptor input: desc_valid (in, 1), desc_ready (out, 1), desc_addr (in, 32, byte address), desc_beats (in, 16, beat count).
REQ-007 The block SHALL have an AR channel: m_axi_arvalid (out, 1), m_axi_arready (in, 1), m_axi_araddr (out, 32), m_axi_arlen (out, 8), m_axi_arsize (out, 3), m_axi_arburst (out, 2).
REQ-008 The block SHALL have an R channel: m_axi_rvalid (in, 1), m_axi_rready (out, 1), m_axi_rdata (in, DATA_W), m_axi_rlast (in, 1), m_axi_rresp (in, 2).
REQ-009 The block SHALL have a stream output: out_valid (out, 1), out_ready (in, 1), out_data (out, DATA_W), out_last (out, 1, final beat of the descriptor).
REQ-010 The block SHALL have status outputs: busy (out, 1), done (out, 1, one-cycle pulse), err (out, 1, sticky).

Function
REQ-011 m_axi_arsize SHALL be the constant log2(DATA_W/8) and m_axi_arburst SHALL be the constant INCR (2'b01).
REQ-012 desc_ready SHALL be high only in state IDLE; a descriptor SHALL be accepted on desc_valid & desc_ready.
REQ-013 On acceptance, the block SHALL latch the address with its low log2(DATA_W/8) bits forced to zero, latch the beat count, and clear err.
REQ-014 The AR state machine SHALL have states IDLE, CALC, ISSUE and DRAIN.
REQ-015 IDLE SHALL go to CALC on acceptance of a nonzero-length descriptor.
REQ-016 CALC SHALL compute the burst length as min(remaining beats, MAX_BURST, beats left to the next 4 KB boundary) and SHALL go to ISSUE when the tracking FIFO is not full; otherwise it SHALL stay in CALC.
REQ-017 In ISSUE, m_axi_arvalid SHALL be high with m_axi_araddr and m_axi_arlen (burst length - 1) held stable until m_axi_arready.
REQ-018 On the AR handshake, the block SHALL push the burst length into the tracking FIFO, advance the address by length*DATA_W/8, and decrement the remaining beats.
REQ-019 After the AR handshake, the state SHALL go to CALC if beats remain, else to DRAIN.
REQ-020 DRAIN SHALL return to IDLE when the final R beat is transferred.
REQ-021 No burst SHALL cross a 4 KB boundary.
REQ-022 No more than OUTSTANDING bursts SHALL be in flight at any time.
REQ-023 A descriptor with desc_beats=0 SHALL be accepted, issue no AR, and pulse done on the following cycle.
REQ-024 The R path SHALL have zero latency: out_data = m_axi_rdata, out_valid = m_axi_rvalid & fifo_nonempty, and m_axi_rready = out_ready & fifo_nonempty.
REQ-025 A per-burst beat counter SHALL end each burst at the FIFO-head length; the FIFO SHALL pop on that final beat.
REQ-026 A simultaneous FIFO push and pop SHALL be legal in every occupancy state, including full.
REQ-027 out_last SHALL be high on the last beat of the descriptor's last burst, and done SHALL pulse in the cycle after that beat's handshake.
REQ-028 busy SHALL be high from descriptor acceptance until done.
REQ-029 A new descriptor SHALL NOT be accepted in the same cycle as done.
REQ-030 The AR and R paths SHALL run concurrently, so AR issue continues while data drains.

Reset
REQ-031 While rst_n is low, all state SHALL return to IDLE, the FIFO SHALL be emptied, and the counters SHALL be zeroed.
REQ-032 While rst_n is low, desc_ready, m_axi_arvalid, m_axi_rready, out_valid, out_last, busy, done and err SHALL be 0.
REQ-033 A reset asserted mid-transfer SHALL abandon the transfer; the bench SHALL reset the AXI slave alongside the block.

Configuration
REQ-034 With RDMA_GEN_RESP_CHECK_EN defined, err SHALL set on any R beat with m_axi_rresp != OKAY, or when m_axi_rlast does not match the internal last-beat count.
REQ-035 With RDMA_GEN_RESP_CHECK_EN defined, the transfer SHALL still complete after an error, with done asserted.
REQ-036 Without RDMA_GEN_RESP_CHECK_EN, the rresp and rlast checks SHALL be absent and err SHALL be tied to 0.

Structure
REQ-037 Package rdma_gen_pkg SHALL hold the state-type enum, AXI_BURST_INCR, AXI_RESP_OKAY, BOUNDARY_BYTES=4096, and a function computing beats to the boundary.
REQ-038 Sub-module rdma_len_fifo SHALL implement the tracking FIFO as a parametrised synchronous FIFO (depth OUTSTANDING, width 9) with full, empty and head outputs.

Verification
REQ-039 The bench SHALL send addr=0x1000, beats=32, DATA_W=64, MAX_BURST=16 and check two ARs (0x1000/len 15, 0x1080/len 15), 32 out beats, out_last on beat 32, and a done pulse.
REQ-040 The bench SHALL send addr=0x1FE0, beats=10 (DATA_W=64) and check a split into 0x1FE0/len 3 and 0x2000/len 5.
REQ-041 The bench SHALL send addr=0x0, beats=64 with arready always high, rvalid delayed 50 cycles and OUTSTANDING=4, and check that exactly 4 ARs issue before the first R beat.
REQ-042 The bench SHALL hold out_ready low 20 cycles mid-burst and check rready=0, no data lost and data order preserved.
REQ-043 The bench SHALL send desc_beats=0 and check no arvalid, done one cycle after acceptance, and busy back to 0.
REQ-044 With RDMA_GEN_RESP_CHECK_EN defined, the bench SHALL return rresp=SLVERR on beat 3 and check err=1, the transfer completes, and err clears on the next descriptor acceptance.
